// File: rtl/baud_tick_gen.sv
// baud_tick_gen: fractional-divisor baud generator producing oversample, mid-bit and bit-boundary strobes.
module baud_tick_gen #(
    parameter int DIV_WIDTH    = 16,
    parameter int FRAC_WIDTH   = 8,
    parameter int OVERSAMPLE   = 16,
    parameter int DEFAULT_INT  = 651,
    parameter int DEFAULT_FRAC = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          resync,
    input  logic                          div_load,
    input  logic [DIV_WIDTH-1:0]          div_int_in,
    input  logic [FRAC_WIDTH-1:0]         div_frac_in,
    output logic                          os_tick,
    output logic                          mid_tick,
    output logic                          bit_tick,
    output logic                          baud,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);
    localparam int OW = $clog2(OVERSAMPLE);

    logic [DIV_WIDTH-1:0]  cnt, act_int, sh_int, n_int, last;
    logic [FRAC_WIDTH-1:0] frac_acc, act_frac, sh_frac, n_frac;
    logic [FRAC_WIDTH:0]   fsum;
    logic [OW-1:0]         os_cnt, os_nxt;
    logic                  carry, sh_valid, eop;

    always_comb begin
        n_int  = div_load ? ((div_int_in < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_int_in) : sh_int;
        n_frac = div_load ? div_frac_in : sh_frac;
        last   = act_int + DIV_WIDTH'(carry) - DIV_WIDTH'(1);
        eop    = cnt == last;
        fsum   = {1'b0, frac_acc} + {1'b0, act_frac};
        os_nxt = (os_cnt == OW'(OVERSAMPLE - 1)) ? '0 : os_cnt + OW'(1);
    end

    assign os_phase = os_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            act_int  <= DIV_WIDTH'(DEFAULT_INT);
            act_frac <= FRAC_WIDTH'(DEFAULT_FRAC);
            sh_int   <= DIV_WIDTH'(DEFAULT_INT);
            sh_frac  <= FRAC_WIDTH'(DEFAULT_FRAC);
            sh_valid <= 1'b0;
            cnt      <= '0;
            os_cnt   <= '0;
            frac_acc <= '0;
            carry    <= 1'b0;
            os_tick  <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
            baud     <= 1'b0;
        end else begin
            sh_int   <= n_int;
            sh_frac  <= n_frac;
            os_tick  <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
            if (!enable) begin
                cnt      <= '0;
                os_cnt   <= '0;
                frac_acc <= '0;
                carry    <= 1'b0;
                baud     <= 1'b0;
                if (sh_valid) begin
                    act_int  <= sh_int;
                    act_frac <= sh_frac;
                end
                sh_valid <= div_load;
            end else if (resync) begin
                // a load arriving with resync applies to the very first period
                cnt      <= '0;
                os_cnt   <= '0;
                frac_acc <= '0;
                carry    <= 1'b0;
                baud     <= 1'b0;
                if (div_load || sh_valid) begin
                    act_int  <= n_int;
                    act_frac <= n_frac;
                end
                sh_valid <= 1'b0;
            end else begin
                baud <= cnt < (act_int >> 1);
                if (eop) begin
                    cnt               <= '0;
                    {carry, frac_acc} <= fsum;
                    os_cnt            <= os_nxt;
                    os_tick           <= 1'b1;
                    mid_tick          <= os_cnt == OW'(OVERSAMPLE / 2 - 1);
                    bit_tick          <= os_cnt == OW'(OVERSAMPLE - 1);
                    if (sh_valid) begin
                        act_int  <= sh_int;
                        act_frac <= sh_frac;
                    end
                    sh_valid <= div_load;
                end else begin
                    cnt      <= cnt + DIV_WIDTH'(1);
                    sh_valid <= sh_valid | div_load;
                end
            end
        end
    end
endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: directed stimulus with expected tick times queued for a negedge monitor.
module tb_baud_tick_gen;
    typedef struct {
        int   t;
        logic mid;
        logic bt;
        int   ph;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, enable, resync, div_load;
    logic [15:0] div_int_in;
    logic [7:0]  div_frac_in;
    logic        os_tick, mid_tick, bit_tick, baud;
    logic [3:0]  os_phase;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   last_tick = 0;
    logic quiet = 1'b0;
    exp_t q[$];
    exp_t me;
    int   mt, mn, macc, mcar;

    baud_tick_gen dut (
        .clk(clk), .rst(rst), .enable(enable), .resync(resync), .div_load(div_load),
        .div_int_in(div_int_in), .div_frac_in(div_frac_in),
        .os_tick(os_tick), .mid_tick(mid_tick), .bit_tick(bit_tick),
        .baud(baud), .os_phase(os_phase)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int a, input int e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mid_tick || bit_tick) chk("strobe_without_os", int'(os_tick), 1);
        if (quiet) chk("idle_outputs", int'({os_tick, mid_tick, bit_tick, baud, os_phase}), 0);
        if (os_tick) begin
            last_tick = cyc;
            if (q.size() > 0) begin
                me = q.pop_front();
                chk("tick_time", cyc, me.t);
                chk("tick_mid", int'(mid_tick), int'(me.mid));
                chk("tick_bit", int'(bit_tick), int'(me.bt));
                chk("tick_phase", int'(os_phase), me.ph);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // queue k periods of divisor pi/pf, continuing from the model phase
    task automatic run(input int k, input int pi, input int pf);
        exp_t e;
        int s;
        for (int i = 0; i < k; i++) begin
            mt += pi + mcar;
            e.t = mt;
            e.mid = (mn == 7);
            e.bt = (mn == 15);
            mn = (mn + 1) % 16;
            e.ph = mn;
            s = macc + pf;
            mcar = s >> 8;
            macc = s & 255;
            q.push_back(e);
        end
    endtask

    task automatic drain(input int b);
        int i = 0;
        while (q.size() > 0 && i < b) begin
            tick();
            i++;
        end
        if (q.size() > 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic load(input int li, input int lf);
        div_load = 1'b1;
        div_int_in = 16'(li);
        div_frac_in = 8'(lf);
        tick();
        div_load = 1'b0;
    endtask

    task automatic zero_model();
        mn = 0;
        macc = 0;
        mcar = 0;
    endtask

    task automatic rs_load(input int li, input int lf);
        div_load = 1'b1;
        resync = 1'b1;
        div_int_in = 16'(li);
        div_frac_in = 8'(lf);
        tick();
        div_load = 1'b0;
        resync = 1'b0;
        mt = cyc;
        zero_model();
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int h, f, i;
        rst = 1'b1; enable = 1'b0; resync = 1'b0; div_load = 1'b0;
        div_int_in = '0; div_frac_in = '0;
        repeat (3) tick();
        chk("rst_os_tick", int'(os_tick), 0);
        chk("rst_mid_tick", int'(mid_tick), 0);
        chk("rst_bit_tick", int'(bit_tick), 0);
        chk("rst_baud", int'(baud), 0);
        chk("rst_os_phase", int'(os_phase), 0);
        rst = 1'b0;
        tick();

        // defaults 651 + 10/256
        mt = cyc;
        enable = 1'b1;
        tick();
        zero_model();
        run(18, 651, 10);
        drain(20000);

        // mid-period load of 10: current period finishes at 651
        repeat (100) tick();
        load(10, 0);
        run(1, 651, 10);
        run(8, 10, 0);
        drain(20000);
        run(1, 10, 0);
        h = 0;
        repeat (10) begin
            tick();
            h += int'(baud);
        end
        chk("baud_high_of_10", h, 5);
        drain(200);

        // clamping to 2
        load(0, 0);
        run(1, 10, 0);
        run(6, 2, 0);
        drain(200);
        load(1, 0);
        run(6, 2, 0);
        drain(200);

        // load with resync: 3 + 128/256 gives 3,3,4,3,4...
        rs_load(3, 128);
        run(8, 3, 128);
        drain(200);

        // resync exactly on the last cycle of os_cnt==15 suppresses the tick
        rs_load(10, 0);
        run(15, 10, 0);
        drain(500);
        while (cyc < mt + 9) tick();
        resync = 1'b1;
        tick();
        resync = 1'b0;
        mt = cyc;
        zero_model();
        run(17, 10, 0);
        drain(500);

        // idle 100 cycles mid-bit, load 6 while idle
        repeat (23) tick();
        enable = 1'b0;
        tick();
        quiet = 1'b1;
        repeat (50) tick();
        load(6, 0);
        repeat (48) tick();
        quiet = 1'b0;
        mt = cyc;
        enable = 1'b1;
        tick();
        zero_model();
        run(17, 6, 0);
        drain(500);

        // 256 consecutive periods of 20 + 10/256
        rs_load(20, 10);
        run(257, 20, 10);
        i = 0;
        while (q.size() > 256 && i < 1000) begin
            tick();
            i++;
        end
        f = last_tick;
        drain(20000);
        chk("frac_256_periods", last_tick - f, 20 * 256 + 10);

        // reset mid-period discards a pending shadow
        load(30, 0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        quiet = 1'b1;
        repeat (3) tick();
        quiet = 1'b0;
        rst = 1'b0;
        mt = cyc;
        tick();
        zero_model();
        run(3, 651, 10);
        drain(5000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
